// File: rtl/fetch_pq.sv
// Instruction fetch unit with a QDEPTH-entry prefetch queue in front of decode.
// Streams sequential words from a one-cycle synchronous SRAM; a non-zero pc_sel redirects and flushes.
module fetch_pq #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned QDEPTH     = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    pc_sel,
    input  logic [ADDR_WIDTH-1:0]         alu_addr,
    input  logic [ADDR_WIDTH-1:0]         imm_addr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_instr,
    output logic [ADDR_WIDTH-1:0]         out_pc,
    output logic [$clog2(QDEPTH+1)-1:0]   q_count,
    input  logic                          cntlr_wr,
    input  logic [ADDR_WIDTH-1:0]         cntlr_waddr,
    input  logic [DATA_WIDTH-1:0]         cntlr_wr_data,
    output logic                          mem_rd,
    output logic [ADDR_WIDTH-1:0]         mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]         mem_rd_data,
    output logic                          mem_wr,
    output logic [ADDR_WIDTH-1:0]         mem_wr_addr,
    output logic [DATA_WIDTH-1:0]         mem_wr_data
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned PW = $clog2(QDEPTH);

    logic [ADDR_WIDTH-1:0] fpc;
    logic [ADDR_WIDTH-1:0] pend_pc;
    logic                  pend;
    logic                  pend_kill;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;

    logic [ADDR_WIDTH-1:0] q_pc    [QDEPTH];
    logic [DATA_WIDTH-1:0] q_instr [QDEPTH];

    logic                  redirect;
    logic                  pop;
    logic                  push;
    logic [CW:0]           credit;
    logic [ADDR_WIDTH-1:0] redirect_pc;

    // Handshake, credit-based issue and redirect target selection
    always_comb begin
        redirect    = (pc_sel != 2'b00);
        pop         = (count != '0) && out_ready && !redirect;
        push        = pend && !pend_kill && !redirect;
        credit      = (CW+1)'(count) + (CW+1)'(pend) - (CW+1)'(pop);
        mem_rd      = rst_n && !redirect && !cntlr_wr && (credit < (CW+1)'(QDEPTH));
        mem_rd_addr = fpc;
        redirect_pc = RESET_PC;
        unique case (pc_sel)
            2'b01:   redirect_pc = alu_addr;
            2'b10:   redirect_pc = imm_addr;
            default: redirect_pc = RESET_PC;
        endcase
    end

    // Controller write path straight through to the SRAM
    always_comb begin
        mem_wr      = cntlr_wr && rst_n;
        mem_wr_addr = cntlr_waddr;
        mem_wr_data = cntlr_wr_data;
    end

    // Fetch PC, queue pointers and in-flight read tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc       <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            pend      <= 1'b0;
            pend_pc   <= '0;
            pend_kill <= 1'b0;
        end else begin
            if (redirect) begin
                fpc    <= redirect_pc;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (mem_rd) fpc    <= fpc + ADDR_WIDTH'(1);
                if (push)   wr_ptr <= wr_ptr + PW'(1);
                if (pop)    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
            pend <= mem_rd;
            if (mem_rd) pend_pc <= fpc;
            // Anything still in flight across a redirect belongs to the old stream
            pend_kill <= redirect;
        end
    end

    // Queue storage needs no reset; out_valid qualifies it
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= pend_pc;
            q_instr[wr_ptr] <= mem_rd_data;
        end
    end

    always_comb begin
        out_valid = (count != '0);
        out_pc    = q_pc[rd_ptr];
        out_instr = q_instr[rd_ptr];
        q_count   = count;
    end

endmodule

// File: doc/fetch_pq.md
# fetch_pq

Parametrised instruction-fetch unit with a prefetch queue, successor to `fetch`. It sits between the instruction SRAM (`sram_8kb`, one-cycle synchronous read) and decode. It streams sequential instructions into a `QDEPTH`-entry queue and hands each one to decode over a valid/ready handshake with its PC. A non-zero `pc_sel` redirects fetch and flushes the queue. The controller write path into the same SRAM is kept.

## Interface
- `ADDR_WIDTH`, 11: word-address width; PC wraps modulo 2^ADDR_WIDTH.
- `DATA_WIDTH`, 32: instruction width.
- `QDEPTH`, 4: prefetch queue entries; power of two, ≥2.
- `RESET_PC`, 0: PC loaded at reset and on `pc_sel`=11.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `pc_sel`  in  2  00 sequential; 01 redirect to `alu_addr`; 10 redirect to `imm_addr`; 11 redirect to `RESET_PC`. Any non-zero value is a one-cycle redirect.
- `alu_addr`, `imm_addr`  in  ADDR_WIDTH  redirect targets, sampled only when selected.
- `out_valid`  out  1  head entry available to decode.
- `out_ready`  in  1  decode accepts the head entry.
- `out_instr`  out  DATA_WIDTH  head instruction.
- `out_pc`  out  ADDR_WIDTH  word address of the head instruction.
- `q_count`  out  $clog2(QDEPTH+1)  current queue occupancy.
- `cntlr_wr`, `cntlr_waddr`, `cntlr_wr_data`  in  1/ADDR_WIDTH/DATA_WIDTH  controller SRAM write.
- `mem_rd`, `mem_rd_addr`  out  1/ADDR_WIDTH  SRAM read request.
- `mem_rd_data`  in  DATA_WIDTH  SRAM read data, valid the cycle after `mem_rd`.
- `mem_wr`, `mem_wr_addr`, `mem_wr_data`  out  1/ADDR_WIDTH/DATA_WIDTH  SRAM write.

## Operation
- State:
  - `fpc`, the next fetch PC.
  - Circular queue with wrapping rd/wr pointers and a count; each entry holds {pc, instr}.
  - `pend`, a read in flight, with `pend_pc`.
  - `pend_kill`, which marks an in-flight read as stale.
- Pop when `out_valid && out_ready && pc_sel==00`.
- Issue condition, evaluated combinationally:
  - `mem_rd = rst_n && pc_sel==00 && !cntlr_wr && (count + pend - pop) < QDEPTH`.
  - `mem_rd_addr = fpc`.
- On issue:
  - `fpc <= fpc+1`, wrapping from 2^ADDR_WIDTH-1 to 0.
  - `pend <= 1` and `pend_pc <= fpc`; otherwise `pend <= 0`.
- Response: at the edge after a cycle with `pend=1 && !pend_kill` and no redirect, push {`pend_pc`, `mem_rd_data`}. The credit rule guarantees no overflow.
- Redirect cycle (`pc_sel`≠00):
  - `fpc` takes the target.
  - count and pointers go to 0.
  - A read issued in a previous cycle whose data lands later is marked killed and dropped.
  - No issue and no pop; `out_ready` is ignored in this cycle.
- Controller write:
  - `mem_wr = cntlr_wr && rst_n`; `mem_wr_addr`/`mem_wr_data` pass through.
  - Fetch issue is blocked while `cntlr_wr` is high.
  - The queue is not coherent with writes; code that writes instructions must redirect afterwards.
- Simultaneous redirect and `cntlr_wr`: the write completes and the redirect is taken.
- Simultaneous push and pop: count is unchanged and both pointers advance.

## Timing
- Reset values (asynchronous):
  - `fpc`=`RESET_PC`; count, pointers, `pend`, `pend_kill` = 0.
  - `out_valid`=0, `q_count`=0, `mem_rd`=0, `mem_wr`=0.
  - `out_instr`/`out_pc` hold the entry-0 contents (don't care while invalid).
- Reset asserted mid-operation: the queue empties at once and an in-flight read is discarded.
- Latency from a redirect or reset release to `out_valid`: redirect in cycle 0, `mem_rd` in cycle 1, data in cycle 2, `out_valid`=1 in cycle 3.
- Throughput: one instruction per cycle with `out_ready` held high, for any `QDEPTH`≥2.
- Backpressure with `out_ready`=0: the queue fills to exactly `QDEPTH`, `mem_rd` drops, and `fpc` stops at head PC+`QDEPTH`.
- Outputs `out_*` and `q_count` are registered-state driven; `mem_rd`/`mem_wr` are combinational from `pc_sel`/`cntlr_wr`.

## Test plan
- Preload: controller writes words 5, 6, 7 = A5A5_0001/0002/0003 with `pc_sel`=00 throughout.
  - `mem_rd` must be low in each write cycle.
  - `fpc` must not advance during those cycles.
- Redirect: `pc_sel`=01 with `alu_addr`=5 for one cycle, then `out_ready`=1.
  - `out_valid` rises 3 cycles after the redirect.
  - Outputs in successive cycles: (5,A5A5_0001), (6,A5A5_0002), (7,A5A5_0003).
- Backpressure, `QDEPTH`=4: `out_ready`=0 after a redirect to 5.
  - `q_count` saturates at 4 and `mem_rd` stays 0.
  - After releasing `out_ready`, PCs 5..12 emerge in order with no gap or duplicate.
- Flush: redirect (`pc_sel`=10, `imm_addr`=7) while the queue holds 3 entries and a read is in flight.
  - `q_count` goes to 0 the next cycle.
  - The next output is (7,A5A5_0003); no stale entry appears.
- Wrap: redirect to 2046.
  - PCs 2046, 2047, 0, 1 are output in sequence.
- Reset mid-stream: drop `rst_n` asynchronously with the queue full.
  - All outputs take their reset values immediately.
  - After release, the first output is PC `RESET_PC`.
